// File: rtl/fetch_if.sv
// Fetch-unit bus: decoder/datapath operands in, instruction memory handshake, and fetched-instruction state out.
// master = fetch unit side, slave = core/imem environment side.
interface fetch_if;
  logic [1:0]  jsel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] rs_val;
  logic        ex_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  modport master (
    input  jsel, br_taken, imm16, addr26, rs_val, ex_stall, imem_ready, imem_rdata,
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, addr_err
  );

  modport slave (
    output jsel, br_taken, imm16, addr26, rs_val, ex_stall, imem_ready, imem_rdata,
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, addr_err
  );
endinterface

// File: rtl/fetch_unit.sv
// PC register, next-PC selection and BOOT/FETCH/EXEC fetch sequencer for the MIPS core.
// Define ALIGN_CHECK_EN to trap misaligned jump targets in a sticky HALT state instead of masking them.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

`ifdef ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;
`else
  typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic        r_addr_err;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_next_pc_raw;
  logic [31:0] w_next_pc;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_offset = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

  always_comb begin
    w_next_pc_raw = w_pc_plus4;
    unique case (bus.jsel)
      2'b00: w_next_pc_raw = w_pc_plus4;
      2'b01: w_next_pc_raw = {w_pc_plus4[31:28], bus.addr26, 2'b00};
      2'b10: w_next_pc_raw = bus.br_taken ? (w_pc_plus4 + w_br_offset) : w_pc_plus4;
      2'b11: w_next_pc_raw = bus.rs_val;
      default: w_next_pc_raw = w_pc_plus4;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  assign w_next_pc = w_next_pc_raw;
`else
  // Without the trap, low bits of a jr target are silently dropped.
  assign w_next_pc = w_next_pc_raw & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ready) begin
            r_instr       <= bus.imem_rdata;
            r_state       <= EXEC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!bus.ex_stall) begin
`ifdef ALIGN_CHECK_EN
            if (w_next_pc[1:0] != 2'b00) begin
              r_state       <= HALT;
              r_instr_valid <= 1'b0;
              r_addr_err    <= 1'b1;
            end else begin
              r_pc          <= w_next_pc;
              r_state       <= FETCH;
              r_instr_valid <= 1'b0;
              r_imem_req    <= 1'b1;
            end
`else
            r_pc          <= w_next_pc;
            r_state       <= FETCH;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
`endif
          end
        end
`ifdef ALIGN_CHECK_EN
        HALT: begin
          r_state       <= HALT;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
`endif
        default: begin
          r_state       <= BOOT;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
`ifdef ALIGN_CHECK_EN
  assign bus.addr_err    = r_addr_err;
`else
  assign bus.addr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequential fetch, imem wait states, branch/jump/jr targets,
// EXEC stall, asynchronous reset mid-fetch and misaligned jr handling.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory returns a word derived from its address so each fetch is distinguishable.
  assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
      else begin
        errorCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [1:0] jsel, input logic brTaken, input logic [15:0] imm16,
                               input logic [25:0] addr26, input logic [31:0] rsVal);
    bus.jsel     = jsel;
    bus.br_taken = brTaken;
    bus.imm16    = imm16;
    bus.addr26   = addr26;
    bus.rs_val   = rsVal;
  endtask

  initial begin
    checkCount     = 0;
    errorCount     = 0;
    reset          = 1'b1;
    bus.ex_stall   = 1'b0;
    bus.imem_ready = 1'b1;
    applyStimulus(2'b00, 1'b0, 16'h0000, 26'h0, 32'h0);

    // Reset state
    #3;
    checkOutput("rst_req",   {31'd0, bus.imem_req},    32'd0);
    checkOutput("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    checkOutput("rst_pc",    bus.pc,                   32'h0000_3000);
    checkOutput("rst_instr", bus.instr,                32'h0);
    checkOutput("rst_err",   {31'd0, bus.addr_err},    32'd0);

    @(negedge clk);
    reset = 1'b0;
    checkOutput("boot_req", {31'd0, bus.imem_req}, 32'd0);

    // Sequential fetch with zero-wait imem
    @(negedge clk);
    checkOutput("f0_req",  {31'd0, bus.imem_req},    32'd1);
    checkOutput("f0_addr", bus.imem_addr,            32'h0000_3000);
    checkOutput("f0_val",  {31'd0, bus.instr_valid}, 32'd0);
    @(negedge clk);
    checkOutput("e0_val",   {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("e0_req",   {31'd0, bus.imem_req},    32'd0);
    checkOutput("e0_instr", bus.instr,                32'hDEAD_3000);
    checkOutput("e0_pc4",   bus.pc_plus4,             32'h0000_3004);
    @(negedge clk);
    checkOutput("f1_addr", bus.imem_addr, 32'h0000_3004);
    @(negedge clk);
    checkOutput("e1_val",   {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("e1_instr", bus.instr,                32'hDEAD_3004);
    @(negedge clk);
    checkOutput("f2_addr", bus.imem_addr, 32'h0000_3008);

    // Three wait cycles on imem: request held four cycles at a constant address
    bus.imem_ready = 1'b0;
    checkOutput("w0_req", {31'd0, bus.imem_req}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checkOutput("wN_req",  {31'd0, bus.imem_req},    32'd1);
      checkOutput("wN_addr", bus.imem_addr,            32'h0000_3008);
      checkOutput("wN_val",  {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    @(negedge clk);
    checkOutput("w_val",   {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("w_instr", bus.instr,                32'hDEAD_3008);

    // Backward branch by -4 taken returns to the same pc
    applyStimulus(2'b10, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    @(negedge clk);
    checkOutput("br_t_pc", bus.pc, 32'h0000_3008);
    @(negedge clk);
    applyStimulus(2'b10, 1'b0, 16'hFFFF, 26'h0, 32'h0);
    @(negedge clk);
    checkOutput("br_nt_pc", bus.pc, 32'h0000_300C);

    // jr into the top segment, then j within it
    @(negedge clk);
    applyStimulus(2'b11, 1'b0, 16'h0, 26'h0, 32'hF000_3000);
    @(negedge clk);
    checkOutput("jr_pc", bus.pc, 32'hF000_3000);
    @(negedge clk);
    checkOutput("j_pc4", bus.pc_plus4, 32'hF000_3004);
    applyStimulus(2'b01, 1'b0, 16'h0, 26'h0000C10, 32'h0);
    @(negedge clk);
    checkOutput("j_pc", bus.pc, 32'hF000_3040);

    // Stall two cycles in EXEC
    @(negedge clk);
    applyStimulus(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    bus.ex_stall = 1'b1;
    checkOutput("st0_val", {31'd0, bus.instr_valid}, 32'd1);
    @(negedge clk);
    checkOutput("st1_val", {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("st1_pc",  bus.pc,                   32'hF000_3040);
    @(negedge clk);
    checkOutput("st2_val", {31'd0, bus.instr_valid}, 32'd1);
    checkOutput("st2_pc",  bus.pc,                   32'hF000_3040);
    bus.ex_stall = 1'b0;
    @(negedge clk);
    checkOutput("st_rel_pc",  bus.pc,                32'hF000_3044);
    checkOutput("st_rel_req", {31'd0, bus.imem_req}, 32'd1);

    // Asynchronous reset in the middle of a fetch
    bus.imem_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("ar_req", {31'd0, bus.imem_req},    32'd0);
    checkOutput("ar_val", {31'd0, bus.instr_valid}, 32'd0);
    checkOutput("ar_pc",  bus.pc,                   32'h0000_3000);
    bus.imem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("ar_boot_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    checkOutput("ar_f_addr", bus.imem_addr,         32'h0000_3000);
    checkOutput("ar_f_req",  {31'd0, bus.imem_req}, 32'd1);

    // Misaligned jr target
    @(negedge clk);
    applyStimulus(2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3002);
    @(negedge clk);
`ifdef ALIGN_CHECK_EN
    checkOutput("mis_err", {31'd0, bus.addr_err},    32'd1);
    checkOutput("mis_req", {31'd0, bus.imem_req},    32'd0);
    checkOutput("mis_val", {31'd0, bus.instr_valid}, 32'd0);
    checkOutput("mis_pc",  bus.pc,                   32'h0000_3000);
    applyStimulus(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("halt_err", {31'd0, bus.addr_err}, 32'd1);
    checkOutput("halt_req", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("halt_pc",  bus.pc,                32'h0000_3000);
`else
    checkOutput("mis_pc",  bus.pc,                32'h0000_3000);
    checkOutput("mis_req", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("mis_err", {31'd0, bus.addr_err}, 32'd0);
    applyStimulus(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("after_pc", bus.pc, 32'h0000_3004);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
